// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_sequencer
// Purpose  : Fetch-stage PC owner: issues imem requests, returns instructions
//            to decode, and applies redirect/trap with in-flight fetch kill.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_sequencer #(
    parameter int unsigned          BIT_WIDTH    = 32,
    parameter logic [BIT_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [BIT_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [BIT_WIDTH-1:0] redirect_target,
    input  logic                 trap_valid,
    output logic                 imem_req_valid,
    output logic [BIT_WIDTH-1:0] imem_req_addr,
    input  logic                 imem_req_ready,
    input  logic                 imem_rsp_valid,
    input  logic [31:0]          imem_rsp_data,
    output logic                 inst_valid,
    output logic [31:0]          inst_data,
    output logic [BIT_WIDTH-1:0] inst_pc,
    output logic [BIT_WIDTH-1:0] pc,
    output logic                 misaligned_fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_VALID = 2'd3;

    localparam logic [BIT_WIDTH-1:0] c_pc_step = BIT_WIDTH'(4);

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [BIT_WIDTH-1:0] r_pc;
    logic [BIT_WIDTH-1:0] w_target;
    logic                 r_kill;
    logic                 r_fault;
    logic [31:0]          r_inst_data;
    logic [BIT_WIDTH-1:0] r_inst_pc;
    logic                 w_active;
    logic                 w_redirect;
    logic                 w_misaligned;
    logic                 w_capture;

    assign w_active     = (r_state != S_IDLE);
    assign w_redirect   = w_active && (trap_valid || redirect_valid);
    assign w_misaligned = w_active && !trap_valid && redirect_valid &&
                          (redirect_target[1:0] != 2'b00);
    assign w_target     = (trap_valid || w_misaligned) ? TRAP_VECTOR : redirect_target;
    // A response is kept only if it belongs to the current PC stream
    assign w_capture    = (r_state == S_WAIT) && imem_rsp_valid && !r_kill && !w_redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_REQ;
            S_REQ:   if (imem_req_ready) w_next_state = S_WAIT;
            S_WAIT:  if (imem_rsp_valid) w_next_state = w_capture ? S_VALID : S_REQ;
            S_VALID: if (w_redirect || !stall) w_next_state = S_REQ;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        inst_valid     = 1'b0;
        case (r_state)
            S_REQ:   imem_req_valid = 1'b1;
            S_VALID: inst_valid     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_VECTOR;
            r_kill      <= 1'b0;
            r_fault     <= 1'b0;
            r_inst_data <= '0;
            r_inst_pc   <= '0;
        end else begin
            r_fault <= w_misaligned;

            if (w_redirect) begin
                r_pc <= w_target;
            end else if ((r_state == S_VALID) && !stall) begin
                r_pc <= r_pc + c_pc_step;
            end

            // kill marks the single outstanding fetch as belonging to a stale PC
            if ((r_state == S_REQ) && imem_req_ready) begin
                r_kill <= w_redirect;
            end else if (r_state == S_WAIT) begin
                if (imem_rsp_valid) begin
                    r_kill <= 1'b0;
                end else if (w_redirect) begin
                    r_kill <= 1'b1;
                end
            end

            if (w_capture) begin
                r_inst_data <= imem_rsp_data;
                r_inst_pc   <= r_pc;
            end
        end
    end

    assign imem_req_addr    = r_pc;
    assign pc               = r_pc;
    assign inst_data        = r_inst_data;
    assign inst_pc          = r_inst_pc;
    assign misaligned_fault = r_fault;

endmodule
`default_nettype wire
